// File: rtl/pipeline_pkg.sv
// Shared types for the EX/MEM elastic stage: occupancy state, its encodings,
// and the field layout of the EX/MEM payload.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_HALF  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // EX/MEM payload field widths
    localparam int unsigned RD_W     = 5;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned ALU_W    = 32;
    localparam int unsigned DATA2_W  = 32;
    localparam int unsigned IMM_W    = 32;
    localparam int unsigned RW_W     = 4;
    localparam int unsigned WB_SEL_W = 2;
    localparam int unsigned REG_WE_W = 1;

    // Field LSB offsets, reg-write enable at bit 0
    localparam int unsigned REG_WE_LSB = 0;
    localparam int unsigned WB_SEL_LSB = REG_WE_LSB + REG_WE_W;
    localparam int unsigned RW_LSB     = WB_SEL_LSB + WB_SEL_W;
    localparam int unsigned IMM_LSB    = RW_LSB + RW_W;
    localparam int unsigned DATA2_LSB  = IMM_LSB + IMM_W;
    localparam int unsigned ALU_LSB    = DATA2_LSB + DATA2_W;
    localparam int unsigned PC_LSB     = ALU_LSB + ALU_W;
    localparam int unsigned RD_LSB     = PC_LSB + PC_W;
    localparam int unsigned EXMEM_W    = RD_LSB + RD_W;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [PC_W-1:0]     pc;
        logic [ALU_W-1:0]    alu_result;
        logic [DATA2_W-1:0]  data2;
        logic [IMM_W-1:0]    imm;
        logic [RW_W-1:0]     mem_rw;
        logic [WB_SEL_W-1:0] wb_sel;
        logic [REG_WE_W-1:0] reg_write;
    } exmem_payload_t;

    function automatic logic [1:0] occupancy_of(input stage_state_t s);
        case (s)
            HALF:    occupancy_of = OCC_HALF;
            FULL:    occupancy_of = OCC_FULL;
            default: occupancy_of = OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elastic_pipeline_reg.sv
// Two-entry elastic pipeline register (main + skid) with flush, memory stall
// freeze, registered occupancy and a saturating stall counter.
module elastic_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned       DATA_W     = EXMEM_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    input  logic              FLUSH,
    input  logic              BUSYWAIT,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_COUNT
);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept, emit;

    // Handshakes are suppressed while frozen, flushing or in reset
    assign IN_READY  = !RESET && (state_q != FULL)  && !BUSYWAIT && !FLUSH;
    assign OUT_VALID = !RESET && (state_q != EMPTY) && !BUSYWAIT && !FLUSH;
    assign accept    = IN_VALID && IN_READY;
    assign emit      = OUT_VALID && OUT_READY;

    assign OUT_DATA  = main_q;
    assign OCCUPANCY = occupancy_of(state_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else if (!BUSYWAIT) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = IN_DATA;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (accept && emit) begin
                        main_d = IN_DATA;
                    end else if (accept) begin
                        skid_d  = IN_DATA;
                        state_d = FULL;
                    end else if (emit) begin
                        main_d  = BUBBLE_VAL;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid drains into main; no accept is possible here
                    if (emit) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                        state_d = HALF;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (OUT_VALID && !OUT_READY),
        .count (STALL_COUNT)
    );

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Bench for elastic_pipeline_reg: directed vector table plus randomized run
// against a queue-based reference model.
module tb_elastic_pipeline_reg;

    localparam int unsigned       DW      = 16;
    localparam int unsigned       CW      = 2;
    localparam logic [DW-1:0]     BUB     = 16'hBEEF;
    localparam int unsigned       CNT_MAX = (1 << CW) - 1;
    localparam int unsigned       NV      = 37;

    logic          CLK = 1'b0;
    logic          RESET, IN_VALID, IN_READY, OUT_VALID, OUT_READY, FLUSH, BUSYWAIT;
    logic [DW-1:0] IN_DATA, OUT_DATA;
    logic [1:0]    OCCUPANCY;
    logic [CW-1:0] STALL_COUNT;

    elastic_pipeline_reg #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_DATA     (IN_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_DATA    (OUT_DATA),
        .FLUSH       (FLUSH),
        .BUSYWAIT    (BUSYWAIT),
        .OCCUPANCY   (OCCUPANCY),
        .STALL_COUNT (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: ordered list of held payloads and a saturating count
    logic [DW-1:0] mq[$];
    int unsigned   mcnt = 0;

    typedef struct {
        logic          rst, iv;
        logic [DW-1:0] din;
        logic          ordy, fl, bw;
        logic          e_ir, e_ov;
        logic [DW-1:0] e_dout;
        logic [1:0]    e_occ;
        logic [CW-1:0] e_st;
    } vec_t;

    vec_t tbl[NV];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [DW-1:0] din,
                                input logic ordy, input logic fl, input logic bw,
                                input logic e_ir, input logic e_ov, input logic [DW-1:0] e_dout,
                                input logic [1:0] e_occ, input logic [CW-1:0] e_st);
        vec_t v;
        v.rst = rst; v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl; v.bw = bw;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_dout = e_dout; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Apply inputs mid-cycle, settle, then advance the model at the edge
    task automatic drive(input logic rst, input logic iv, input logic [DW-1:0] din,
                         input logic ordy, input logic fl, input logic bw);
        @(negedge CLK);
        RESET = rst; IN_VALID = iv; IN_DATA = din; OUT_READY = ordy; FLUSH = fl; BUSYWAIT = bw;
        #1;
    endtask

    task automatic model_edge();
        bit m_ir, m_ov;
        @(posedge CLK);
        m_ir = !RESET && (mq.size() < 2) && !BUSYWAIT && !FLUSH;
        m_ov = !RESET && (mq.size() > 0) && !BUSYWAIT && !FLUSH;
        if (RESET) begin
            mq.delete();
            mcnt = 0;
        end else if (FLUSH) begin
            mq.delete();
        end else begin
            if (m_ov && !OUT_READY && mcnt < CNT_MAX) mcnt++;
            if (m_ov && OUT_READY) void'(mq.pop_front());
            if (IN_VALID && m_ir) mq.push_back(IN_DATA);
        end
    endtask

    task automatic check_model(input string tag);
        logic          e_ir, e_ov;
        logic [DW-1:0] e_dout;
        e_ir   = !RESET && (mq.size() < 2) && !BUSYWAIT && !FLUSH;
        e_ov   = !RESET && (mq.size() > 0) && !BUSYWAIT && !FLUSH;
        e_dout = (mq.size() > 0) ? mq[0] : BUB;
        chk({tag, ".in_ready"},  32'(IN_READY),    32'(e_ir));
        chk({tag, ".out_valid"}, 32'(OUT_VALID),   32'(e_ov));
        chk({tag, ".out_data"},  32'(OUT_DATA),    32'(e_dout));
        chk({tag, ".occupancy"}, 32'(OCCUPANCY),   32'(mq.size()));
        chk({tag, ".stall"},     32'(STALL_COUNT), 32'(mcnt));
    endtask

    initial begin
        //            rst iv din      or fl bw   ir ov dout     occ st
        tbl[0]  = mk(1, 1, 16'h0011, 0, 0, 0,  0, 0, BUB,     0, 0);
        tbl[1]  = mk(0, 1, 16'h00A5, 1, 0, 0,  1, 0, BUB,     0, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 1, 0, 0,  1, 1, 16'h00A5, 1, 0);
        tbl[3]  = mk(0, 1, 16'h0001, 0, 0, 0,  1, 0, BUB,     0, 0);
        tbl[4]  = mk(0, 1, 16'h0002, 0, 0, 0,  1, 1, 16'h0001, 1, 0);
        tbl[5]  = mk(0, 1, 16'h0003, 0, 0, 0,  0, 1, 16'h0001, 2, 1);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 0, 0,  0, 1, 16'h0001, 2, 2);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 0, 0,  1, 1, 16'h0002, 1, 2);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 0,  1, 0, BUB,     0, 2);
        tbl[9]  = mk(1, 0, 16'h0000, 0, 0, 0,  0, 0, BUB,     0, 2);
        tbl[10] = mk(0, 1, 16'h0001, 0, 0, 0,  1, 0, BUB,     0, 0);
        tbl[11] = mk(0, 1, 16'h0002, 0, 0, 0,  1, 1, 16'h0001, 1, 0);
        tbl[12] = mk(0, 1, 16'h0007, 1, 0, 1,  0, 0, 16'h0001, 2, 1);
        tbl[13] = mk(0, 1, 16'h0007, 0, 0, 1,  0, 0, 16'h0001, 2, 1);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 1,  0, 0, 16'h0001, 2, 1);
        tbl[15] = mk(0, 0, 16'h0000, 1, 0, 0,  0, 1, 16'h0001, 2, 1);
        tbl[16] = mk(0, 0, 16'h0000, 1, 0, 0,  1, 1, 16'h0002, 1, 1);
        tbl[17] = mk(0, 0, 16'h0000, 1, 0, 0,  1, 0, BUB,     0, 1);
        tbl[18] = mk(0, 1, 16'h0001, 0, 0, 0,  1, 0, BUB,     0, 1);
        tbl[19] = mk(0, 1, 16'h0002, 0, 0, 0,  1, 1, 16'h0001, 1, 1);
        tbl[20] = mk(0, 1, 16'h0003, 1, 1, 0,  0, 0, 16'h0001, 2, 2);
        tbl[21] = mk(0, 0, 16'h0000, 1, 0, 0,  1, 0, BUB,     0, 2);
        tbl[22] = mk(0, 0, 16'h0000, 1, 0, 0,  1, 0, BUB,     0, 2);
        tbl[23] = mk(1, 0, 16'h0000, 0, 0, 0,  0, 0, BUB,     0, 2);
        tbl[24] = mk(0, 1, 16'h0044, 0, 0, 0,  1, 0, BUB,     0, 0);
        tbl[25] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 0);
        tbl[26] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 1);
        tbl[27] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 2);
        tbl[28] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 3);
        tbl[29] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 3);
        tbl[30] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 3);
        tbl[31] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 1, 16'h0044, 1, 3);
        tbl[32] = mk(0, 1, 16'h0055, 0, 0, 0,  1, 1, 16'h0044, 1, 3);
        tbl[33] = mk(1, 1, 16'h0066, 0, 1, 0,  0, 0, 16'h0044, 2, 3);
        tbl[34] = mk(0, 0, 16'h0000, 0, 0, 0,  1, 0, BUB,     0, 0);
        tbl[35] = mk(0, 1, 16'h0077, 1, 0, 0,  1, 0, BUB,     0, 0);
        tbl[36] = mk(0, 0, 16'h0000, 1, 0, 0,  1, 1, 16'h0077, 1, 0);

        RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0; FLUSH = 1'b0; BUSYWAIT = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, '0, 0, 0, 0);
            model_edge();
        end

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].fl, tbl[i].bw);
            chk({tag, ".in_ready"},  32'(IN_READY),    32'(tbl[i].e_ir));
            chk({tag, ".out_valid"}, 32'(OUT_VALID),   32'(tbl[i].e_ov));
            chk({tag, ".out_data"},  32'(OUT_DATA),    32'(tbl[i].e_dout));
            chk({tag, ".occupancy"}, 32'(OCCUPANCY),   32'(tbl[i].e_occ));
            chk({tag, ".stall"},     32'(STALL_COUNT), 32'(tbl[i].e_st));
            model_edge();
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            logic          r_rst, r_iv, r_or, r_fl, r_bw;
            logic [DW-1:0] r_d;
            r_rst = ($urandom_range(99) < 2);
            r_fl  = ($urandom_range(99) < 5);
            r_bw  = ($urandom_range(99) < 15);
            r_iv  = ($urandom_range(99) < 60);
            r_or  = ($urandom_range(99) < 55);
            r_d   = DW'($urandom);
            drive(r_rst, r_iv, r_d, r_or, r_fl, r_bw);
            check_model($sformatf("rnd%0d", i));
            model_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elastic_pipeline_reg.md
ELASTIC_PIPELINE_REG -- requirements
Module: elastic_pipeline_reg

Interface
REQ-001 Parameter DATA_W, default 140, SHALL set the width of the packed stage payload (rd, PC, ALU result, data2, immediate, read/write, WB select, reg-write enable).
REQ-002 Parameter BUBBLE_VAL, default 0, SHALL set the payload value loaded on reset, flush and drain.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-high.
REQ-006 IN_VALID  input  1  upstream payload valid.
REQ-007 IN_READY  output  1  stage can accept a payload this cycle.
REQ-008 IN_DATA  input  DATA_W  upstream payload.
REQ-009 OUT_VALID  output  1  OUT_DATA holds a valid payload.
REQ-010 OUT_READY  input  1  downstream accepts the payload.
REQ-011 OUT_DATA  output  DATA_W  payload to the next stage, driven directly from the main register.
REQ-012 FLUSH  input  1  discard all held payloads (branch/jump kill).
REQ-013 BUSYWAIT  input  1  memory stall; freezes the stage.
REQ-014 OCCUPANCY  output  2  number of held payloads (0..2).
REQ-015 STALL_COUNT  output  CNT_W  cycles spent with OUT_VALID=1 and OUT_READY=0.

Function
REQ-016 The stage SHALL hold a main register and one skid register, with state EMPTY (0 held), HALF (1 held) or FULL (2 held).
REQ-017 IN_READY SHALL equal (state != FULL) & !BUSYWAIT & !FLUSH, combinationally.
REQ-018 OUT_VALID SHALL equal (state != EMPTY) & !BUSYWAIT & !FLUSH, combinationally.
REQ-019 Accept = IN_VALID & IN_READY; emit = OUT_VALID & OUT_READY.
REQ-020 From EMPTY, accept SHALL load main with IN_DATA and move to HALF, giving 1-cycle latency.
REQ-021 From HALF, accept with emit SHALL load main with IN_DATA and stay in HALF.
REQ-022 From HALF, accept without emit SHALL load skid with IN_DATA and move to FULL.
REQ-023 From HALF, emit without accept SHALL load main with BUBBLE_VAL and move to EMPTY.
REQ-024 From FULL, emit SHALL move skid to main and go to HALF; no accept is possible in FULL.
REQ-025 With neither accept nor emit, state and registers SHALL hold.
REQ-026 While BUSYWAIT=1 and FLUSH=0, all registers SHALL hold and STALL_COUNT SHALL NOT increment.
REQ-027 FLUSH=1 SHALL, at the next edge, set state EMPTY, load main and skid with BUBBLE_VAL and discard any same-cycle input; FLUSH SHALL override BUSYWAIT.
REQ-028 OCCUPANCY SHALL be registered and equal the state encoding: 0, 1 or 2.
REQ-029 STALL_COUNT SHALL increment when OUT_VALID & !OUT_READY, saturate at all-ones without wrapping, and be cleared only by RESET.
REQ-030 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by FLUSH or RESET.

Reset
REQ-031 RESET SHALL take precedence over FLUSH, BUSYWAIT and every handshake.
REQ-032 On reset the stage SHALL set state EMPTY, main = skid = BUBBLE_VAL, OCCUPANCY = 0 and STALL_COUNT = 0.
REQ-033 Reset asserted mid-transfer SHALL discard both held payloads.
REQ-034 IN_READY and OUT_VALID SHALL be 0 during the reset cycle; outputs SHALL be valid from the first edge after RESET falls.

Structure
REQ-035 Package pipeline_pkg SHALL hold the state typedef (EMPTY/HALF/FULL), the occupancy constants and the EX/MEM payload field widths/offsets.
REQ-036 The saturating counter SHALL be the sub-module sat_counter, parameterised by CNT_W; the rest of the design SHALL be inline.

Verification
REQ-037 Reset, then IN_DATA=0xA5 with IN_VALID=1 and OUT_READY=1 -> OUT_VALID=1 and OUT_DATA=0xA5 one edge later, OCCUPANCY=1.
REQ-038 OUT_READY=0, push 0x1 then 0x2 -> OCCUPANCY=2 and IN_READY=0; with OUT_READY=1 -> 0x1 then 0x2 appear on consecutive cycles, then OCCUPANCY=0 and OUT_DATA=BUBBLE_VAL.
REQ-039 FULL with BUSYWAIT=1 for 3 cycles -> OUT_VALID=0, contents and STALL_COUNT unchanged, 0x1 emitted after release.
REQ-040 FULL, FLUSH=1 together with IN_VALID=1 (0x3) -> next cycle EMPTY, OUT_DATA=BUBBLE_VAL, 0x3 never emitted.
REQ-041 CNT_W=2, hold OUT_READY=0 for 6 cycles with data held -> STALL_COUNT 1,2,3,3,3,3.
REQ-042 RESET asserted while FULL with FLUSH=1 -> all outputs at reset values, STALL_COUNT=0.
